// File: rtl/seq_bcd_converter.sv
// Iterative double-dabble binary-to-BCD converter: one shift per clock with a start/busy/done handshake.
// Define SIGN_MAG_EN to treat `binary` as two's complement and report the sign on `negative`.
module seq_bcd_converter #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [WIDTH-1:0]      binary,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd
`ifdef SIGN_MAG_EN
   ,
   output logic                  negative
`endif
);

   localparam int SW = 4 * DIGITS;
   localparam int TW = SW + WIDTH;
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   function automatic logic [SW-1:0] add3_digits(input logic [SW-1:0] s);
      logic [SW-1:0] r;
      r = s;
      for (int i = 0; i < DIGITS; i++) begin
         if (s[4*i +: 4] >= 4'd5) begin
            r[4*i +: 4] = s[4*i +: 4] + 4'd3;
         end
      end
      return r;
   endfunction

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [SW-1:0]    scratch_q, scratch_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [SW-1:0]    bcd_q, bcd_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] mag_s;
   logic [TW-1:0]    work_s;
`ifdef SIGN_MAG_EN
   logic             sign_q, sign_d;
   logic             negative_q, negative_d;
`endif

   // Adjust every scratch digit, then shift the combined register left once
   always_comb begin
      work_s = {add3_digits(scratch_q), shift_q} << 1;
`ifdef SIGN_MAG_EN
      mag_s  = binary[WIDTH-1] ? (~binary + WIDTH'(1)) : binary;
`else
      mag_s  = binary;
`endif
   end

   // Next-state and datapath control
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      scratch_d = scratch_q;
      cnt_d     = cnt_q;
      bcd_d     = bcd_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
`ifdef SIGN_MAG_EN
      sign_d     = sign_q;
      negative_d = negative_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               shift_d   = mag_s;
               scratch_d = '0;
               cnt_d     = CW'(WIDTH);
               busy_d    = 1'b1;
               state_d   = S_SHIFT;
`ifdef SIGN_MAG_EN
               sign_d    = binary[WIDTH-1];
`endif
            end
         end
         S_SHIFT: begin
            scratch_d = work_s[TW-1:WIDTH];
            shift_d   = work_s[WIDTH-1:0];
            cnt_d     = cnt_q - CW'(1);
            // The last shift lands straight in the output register
            if (cnt_q == CW'(1)) begin
               bcd_d   = work_s[TW-1:WIDTH];
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = S_DONE;
`ifdef SIGN_MAG_EN
               negative_d = sign_q;
`endif
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         shift_q   <= '0;
         scratch_q <= '0;
         cnt_q     <= '0;
         bcd_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef SIGN_MAG_EN
         sign_q     <= 1'b0;
         negative_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         scratch_q <= scratch_d;
         cnt_q     <= cnt_d;
         bcd_q     <= bcd_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
`ifdef SIGN_MAG_EN
         sign_q     <= sign_d;
         negative_q <= negative_d;
`endif
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign bcd  = bcd_q;
`ifdef SIGN_MAG_EN
   assign negative = negative_q;
`endif

endmodule

// File: tb/tb_seq_bcd_converter.sv
// Scoreboard bench for seq_bcd_converter: driver pushes decimal-digit expectations, monitor checks on done.
module tb_seq_bcd_converter;

   localparam int W = 16;
   localparam int D = 5;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           start = 1'b0;
   logic [W-1:0]   binary = '0;
   logic           busy;
   logic           done;
   logic [4*D-1:0] bcd;
`ifdef SIGN_MAG_EN
   logic           negative;
`endif

   seq_bcd_converter #(.WIDTH(W), .DIGITS(D)) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .binary(binary),
      .busy(busy),
      .done(done),
      .bcd(bcd)
`ifdef SIGN_MAG_EN
      ,
      .negative(negative)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4*D-1:0] bcd;
      logic           neg;
      int             cyc;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: plain decimal digit extraction from the (possibly signed) value
   task automatic push_expect(input logic [W-1:0] v, input int done_cyc);
      exp_t        e;
      int unsigned m;
      m     = v;
      e.neg = 1'b0;
`ifdef SIGN_MAG_EN
      if (v[W-1]) begin
         m     = (1 << W) - m;
         e.neg = 1'b1;
      end
`endif
      e.bcd = '0;
      for (int i = 0; i < D; i++) begin
         e.bcd[4*i +: 4] = 4'(m % 10);
         m = m / 10;
      end
      e.cyc = done_cyc;
      q.push_back(e);
   endtask

   // Monitor: busy window, done timing and result
   always @(negedge clk) begin
      exp_t f;
      logic exp_busy;
      if (!rst) begin
         exp_busy = 1'b0;
         if (q.size() > 0 && cyc >= q[0].cyc - W && cyc < q[0].cyc) exp_busy = 1'b1;
         check("busy", {31'd0, busy}, {31'd0, exp_busy});
         if (done) begin
            if (q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
            end else begin
               f = q.pop_front();
               check("bcd", {12'd0, bcd}, {12'd0, f.bcd});
               check("done_cycle", cyc, f.cyc);
`ifdef SIGN_MAG_EN
               check("negative", {31'd0, negative}, {31'd0, f.neg});
`endif
            end
         end else if (q.size() > 0 && cyc >= q[0].cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_missing: got done=0 expected 1 (cycle %0d)", cyc);
            void'(q.pop_front());
         end
      end
   end

   task automatic convert(input logic [W-1:0] v);
      @(negedge clk);
      start  = 1'b1;
      binary = v;
      push_expect(v, cyc + 1 + W);
      @(negedge clk);
      start  = 1'b0;
      binary = W'($urandom);
      repeat (W + 2) @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      #1;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_bcd", {12'd0, bcd}, 32'd0);
`ifdef SIGN_MAG_EN
      check("rst_negative", {31'd0, negative}, 32'd0);
`endif
      @(negedge clk);
      #2 rst = 1'b0;

      convert(16'h0000);
`ifdef SIGN_MAG_EN
      convert(16'hFF85);
      convert(16'h8000);
      convert(16'h007B);
      convert(16'hFFFF);
`else
      convert(16'hFFFF);
`endif

      // Starts pulsed mid-conversion must be ignored
      @(negedge clk);
      start  = 1'b1;
      binary = 16'd12345;
      push_expect(16'd12345, cyc + 1 + W);
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      start  = 1'b1;
      binary = 16'd1;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      start  = 1'b1;
      binary = 16'd2;
      @(negedge clk);
      start = 1'b0;
      repeat (W) @(negedge clk);

      // Abort by reset, then a fresh conversion
      convert(16'd999);
      @(negedge clk);
      start  = 1'b1;
      binary = 16'd42;
      push_expect(16'd42, cyc + 1 + W);
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      #2 rst = 1'b1;
      q.delete();
      #1;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_bcd", {12'd0, bcd}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      repeat (3) @(negedge clk);
      convert(16'd42);

      // start held high: back-to-back conversions W+2 cycles apart
      @(negedge clk);
      start  = 1'b1;
      binary = 16'd100;
      push_expect(16'd100, cyc + 1 + W);
      @(negedge clk);
      binary = 16'd7;
      push_expect(16'd7, cyc + W + 2 + 1 + W - 1);
      repeat (W + 2) @(negedge clk);
      start = 1'b0;
      repeat (W + 2) @(negedge clk);

      // Randomized conversions with random idle gaps
      for (int n = 0; n < 20; n++) begin
         convert(W'($urandom_range(0, (1 << W) - 1)));
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      repeat (4) @(negedge clk);
      check("queue_drained", q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
